// File: rtl/pipeline_pkg.sv
// Shared pipeline types and control-field bit positions used by the MEM stage.
package pipeline_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  localparam int MEMREAD_BIT  = 1;
  localparam int MEMWRITE_BIT = 0;
  localparam int REGWRITE_BIT = 1;
  localparam int MEMTOREG_BIT = 0;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic isMisaligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if;
  // req rises for a new access and stays high, with we/addr/wdata stable,
  // until the memory returns a single-cycle ack (rdata valid with ack) or
  // the master abandons the access (timeout or reset).
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_timeout_ctr.sv
// Clear/enable counter flagging the last cycle an access may wait for ack.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores on the data-memory port, stalls upstream
// while waiting for ack, and loads the MEM/WB register.
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_mem_valid,
  input  logic [31:0]         ex_mem_alu_result,
  input  logic [31:0]         ex_mem_store_data,
  input  logic [4:0]          ex_mem_rd,
  input  logic [1:0]          ex_mem_mem_ctrl,
  input  logic [1:0]          ex_mem_wb_ctrl,
  output logic                stall,
  mem_access_stage_if.master  dmem,
  output logic                wb_valid,
  output logic [31:0]         wb_read_data,
  output logic [31:0]         wb_alu_result,
  output logic [4:0]          wb_rd,
  output logic [1:0]          wb_ctrl,
  output logic                mem_err,
  output mem_state_t          dbgState
);

  mem_state_t state, nextState;
  logic memRead, memWrite, memOp, illegal, misaligned, issue;
  logic ctrClear, ctrEn, ctrTc;
  logic accessDone, accessTimeout, wbErr;
  logic [1:0] wbCtrlNext;

  assign memRead    = ex_mem_mem_ctrl[MEMREAD_BIT];
  assign memWrite   = ex_mem_mem_ctrl[MEMWRITE_BIT];
  assign memOp      = ex_mem_valid & (memRead ^ memWrite);
  assign illegal    = ex_mem_valid & memRead & memWrite;
  assign misaligned = memOp & isMisaligned(ex_mem_alu_result);
  assign issue      = memOp & ~misaligned;
  assign dbgState   = state;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (ctrClear),
    .en    (ctrEn),
    .tc    (ctrTc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState     = state;
    stall         = 1'b0;
    ctrClear      = 1'b0;
    ctrEn         = 1'b0;
    accessDone    = 1'b0;
    accessTimeout = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          nextState = ACCESS;
          stall     = 1'b1;
          ctrClear  = 1'b1;
        end
      end
      ACCESS: begin
        // A late ack on the terminal cycle still completes the access.
        if (dmem.ack) begin
          nextState  = IDLE;
          accessDone = 1'b1;
        end else if (ctrTc) begin
          nextState     = IDLE;
          accessTimeout = 1'b1;
        end else begin
          stall = 1'b1;
          ctrEn = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  assign wbErr = ((state == IDLE) & (illegal | misaligned)) | accessTimeout;

  always_comb begin
    wbCtrlNext = ex_mem_wb_ctrl;
    if (wbErr) wbCtrlNext[REGWRITE_BIT] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem.req      <= 1'b0;
      dmem.we       <= 1'b0;
      dmem.addr     <= '0;
      dmem.wdata    <= '0;
      wb_valid      <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_rd         <= '0;
      wb_ctrl       <= '0;
      mem_err       <= 1'b0;
    end else begin
      if (state == IDLE && issue) begin
        dmem.req   <= 1'b1;
        dmem.we    <= memWrite;
        dmem.addr  <= ex_mem_alu_result;
        dmem.wdata <= ex_mem_store_data;
      end else if (accessDone || accessTimeout) begin
        dmem.req <= 1'b0;
      end

      // A stalled cycle inserts a bubble; the data fields keep their last value.
      if (stall) begin
        wb_valid <= 1'b0;
        mem_err  <= 1'b0;
      end else begin
        wb_valid      <= ex_mem_valid;
        wb_alu_result <= ex_mem_alu_result;
        wb_rd         <= ex_mem_rd;
        wb_ctrl       <= wbCtrlNext;
        mem_err       <= wbErr;
        wb_read_data  <= (accessDone && !dmem.we) ? dmem.rdata : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads, stores,
// alignment/control errors, timeout and reset during an access.
module tb_mem_access_stage;
  import pipeline_pkg::*;

  logic        clk;
  logic        rst;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_store_data;
  logic [4:0]  ex_mem_rd;
  logic [1:0]  ex_mem_mem_ctrl;
  logic [1:0]  ex_mem_wb_ctrl;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_read_data;
  logic [31:0] wb_alu_result;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_ctrl;
  logic        mem_err;
  mem_state_t  dbg_state;

  mem_access_stage_if dmem_bus ();

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] exp_q[$];

  mem_access_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_store_data (ex_mem_store_data),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_mem_ctrl   (ex_mem_mem_ctrl),
    .ex_mem_wb_ctrl    (ex_mem_wb_ctrl),
    .stall             (stall),
    .dmem              (dmem_bus),
    .wb_valid          (wb_valid),
    .wb_read_data      (wb_read_data),
    .wb_alu_result     (wb_alu_result),
    .wb_rd             (wb_rd),
    .wb_ctrl           (wb_ctrl),
    .mem_err           (mem_err),
    .dbgState          (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] mc, input logic [1:0] wc,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd);
    ex_mem_valid      = v;
    ex_mem_mem_ctrl   = mc;
    ex_mem_wb_ctrl    = wc;
    ex_mem_alu_result = alu;
    ex_mem_store_data = sd;
    ex_mem_rd         = rd;
    #1;
  endtask

  task automatic drive_nop();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic set_ack(input logic a, input logic [31:0] d);
    dmem_bus.ack   = a;
    dmem_bus.rdata = d;
  endtask

  // scoreboard: every valid MEM/WB slot must match the next expected ALU result
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) check_eq("sb_unexpected_wb", 32'(wb_valid), 32'd0);
      else                   check_eq("sb_wb_alu", wb_alu_result, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    set_ack(1'b0, 32'h0);
    drive_nop();
    tick();
    tick();

    // reset state, and stall held low under reset even with a load present
    check_eq("rst_req", 32'(dmem_bus.req), 32'd0);
    check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("rst_wb_ctrl", 32'(wb_ctrl), 32'd0);
    check_eq("rst_mem_err", 32'(mem_err), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    drive(1'b1, 2'b10, 2'b11, 32'h100, 32'h0, 5'd1);
    check_eq("rst_stall", 32'(stall), 32'd0);
    drive_nop();
    rst = 1'b0;

    // 1: plain ALU op, one-cycle pass-through
    exp_q.push_back(32'h42);
    drive(1'b1, 2'b00, 2'b10, 32'h42, 32'h0, 5'd5);
    check_eq("alu_stall", 32'(stall), 32'd0);
    tick();
    drive_nop();
    check_eq("alu_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("alu_wb_alu", wb_alu_result, 32'h42);
    check_eq("alu_wb_rd", 32'(wb_rd), 32'd5);
    check_eq("alu_wb_ctrl", 32'(wb_ctrl), 32'h2);
    check_eq("alu_mem_err", 32'(mem_err), 32'd0);
    check_eq("alu_req", 32'(dmem_bus.req), 32'd0);

    // 2: load, ack on the 4th request cycle (counter at TIMEOUT-1)
    exp_q.push_back(32'h100);
    drive(1'b1, 2'b10, 2'b11, 32'h100, 32'h0, 5'd7);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("ld_stall%0d", i), 32'(stall), 32'd1);
      if (i > 0) begin
        check_eq($sformatf("ld_req%0d", i), 32'(dmem_bus.req), 32'd1);
        check_eq($sformatf("ld_addr%0d", i), dmem_bus.addr, 32'h100);
        check_eq($sformatf("ld_we%0d", i), 32'(dmem_bus.we), 32'd0);
        check_eq($sformatf("ld_bubble%0d", i), 32'(wb_valid), 32'd0);
      end
      tick();
    end
    set_ack(1'b1, 32'hDEAD_BEEF);
    #1;
    check_eq("ld_ack_stall", 32'(stall), 32'd0);
    tick();
    set_ack(1'b0, 32'h0);
    drive_nop();
    check_eq("ld_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("ld_wb_rdata", wb_read_data, 32'hDEAD_BEEF);
    check_eq("ld_wb_ctrl", 32'(wb_ctrl), 32'h3);
    check_eq("ld_wb_rd", 32'(wb_rd), 32'd7);
    check_eq("ld_req_drop", 32'(dmem_bus.req), 32'd0);
    check_eq("ld_post_stall", 32'(stall), 32'd0);

    // 3: store acked on the first ACCESS cycle
    exp_q.push_back(32'h200);
    drive(1'b1, 2'b01, 2'b00, 32'h200, 32'h1234_5678, 5'd0);
    check_eq("st_stall", 32'(stall), 32'd1);
    tick();
    check_eq("st_we", 32'(dmem_bus.we), 32'd1);
    check_eq("st_wdata", dmem_bus.wdata, 32'h1234_5678);
    check_eq("st_addr", dmem_bus.addr, 32'h200);
    set_ack(1'b1, 32'hFFFF_FFFF);
    #1;
    check_eq("st_ack_stall", 32'(stall), 32'd0);
    tick();
    set_ack(1'b0, 32'h0);
    drive_nop();
    check_eq("st_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("st_wb_rdata", wb_read_data, 32'h0);
    check_eq("st_req_drop", 32'(dmem_bus.req), 32'd0);

    // 4: misaligned load resolves in IDLE with an error
    exp_q.push_back(32'h102);
    drive(1'b1, 2'b10, 2'b11, 32'h102, 32'h0, 5'd3);
    check_eq("mis_stall", 32'(stall), 32'd0);
    tick();
    drive_nop();
    check_eq("mis_req", 32'(dmem_bus.req), 32'd0);
    check_eq("mis_err", 32'(mem_err), 32'd1);
    check_eq("mis_wb_ctrl", 32'(wb_ctrl), 32'h1);
    check_eq("mis_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("mis_wb_rdata", wb_read_data, 32'h0);
    tick();
    check_eq("mis_err_pulse", 32'(mem_err), 32'd0);

    // illegal control never issues; ack while IDLE is ignored
    exp_q.push_back(32'h300);
    drive(1'b1, 2'b11, 2'b10, 32'h300, 32'h0, 5'd4);
    check_eq("ill_stall", 32'(stall), 32'd0);
    tick();
    drive_nop();
    set_ack(1'b1, 32'h5555_AAAA);
    check_eq("ill_req", 32'(dmem_bus.req), 32'd0);
    check_eq("ill_err", 32'(mem_err), 32'd1);
    check_eq("ill_wb_ctrl", 32'(wb_ctrl), 32'h0);
    tick();
    set_ack(1'b0, 32'h0);
    check_eq("idle_ack_state", 32'(dbg_state), 32'(IDLE));
    check_eq("idle_ack_valid", 32'(wb_valid), 32'd0);
    check_eq("idle_ack_req", 32'(dmem_bus.req), 32'd0);

    // 5: timeout after TIMEOUT=4 stalled cycles, then a back-to-back load
    exp_q.push_back(32'h400);
    drive(1'b1, 2'b10, 2'b11, 32'h400, 32'h0, 5'd9);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("to_stall%0d", i), 32'(stall), 32'd1);
      tick();
    end
    check_eq("to_release", 32'(stall), 32'd0);
    tick();
    exp_q.push_back(32'h500);
    drive(1'b1, 2'b10, 2'b11, 32'h500, 32'h0, 5'd10);
    check_eq("to_req_drop", 32'(dmem_bus.req), 32'd0);
    check_eq("to_err", 32'(mem_err), 32'd1);
    check_eq("to_wb_ctrl", 32'(wb_ctrl), 32'h1);
    check_eq("to_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("to_wb_rdata", wb_read_data, 32'h0);
    check_eq("b2b_stall", 32'(stall), 32'd1);
    tick();
    check_eq("b2b_req", 32'(dmem_bus.req), 32'd1);
    check_eq("b2b_addr", dmem_bus.addr, 32'h500);
    set_ack(1'b1, 32'hCAFE_F00D);
    tick();
    set_ack(1'b0, 32'h0);
    drive_nop();
    check_eq("b2b_rdata", wb_read_data, 32'hCAFE_F00D);
    check_eq("b2b_err", 32'(mem_err), 32'd0);
    check_eq("b2b_wb_ctrl", 32'(wb_ctrl), 32'h3);

    // 6: reset on the second ACCESS cycle abandons the load
    drive(1'b1, 2'b10, 2'b11, 32'h600, 32'hABCD_0000, 5'd11);
    tick();
    tick();
    check_eq("rst6_in_access", 32'(dbg_state), 32'(ACCESS));
    rst = 1'b1;
    #1;
    check_eq("rst6_stall", 32'(stall), 32'd0);
    tick();
    check_eq("rst6_req", 32'(dmem_bus.req), 32'd0);
    check_eq("rst6_state", 32'(dbg_state), 32'(IDLE));
    check_eq("rst6_addr", dmem_bus.addr, 32'h0);
    check_eq("rst6_wb_alu", wb_alu_result, 32'h0);
    check_eq("rst6_wb_rdata", wb_read_data, 32'h0);
    check_eq("rst6_wb_rd", 32'(wb_rd), 32'd0);
    rst = 1'b0;
    drive_nop();
    set_ack(1'b1, 32'h1111_2222);
    check_eq("rst6_late_stall", 32'(stall), 32'd0);
    tick();
    set_ack(1'b0, 32'h0);
    check_eq("rst6_late_valid", 32'(wb_valid), 32'd0);
    check_eq("rst6_late_state", 32'(dbg_state), 32'(IDLE));
    check_eq("rst6_late_req", 32'(dmem_bus.req), 32'd0);

    tick();
    tick();
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns load/store control into a req/ack transaction on the data-memory port.
- Stalls upstream while an access is outstanding, then loads the MEM/WB register fields (read data, ALU result, rd, WB control).
- Sits between the EX/MEM register and the writeback stage.

Parameters:
- TIMEOUT, 255, ACCESS cycles without dmem_ack before the access is abandoned (1..255).
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_mem_valid  in  1  EX/MEM slot holds a real instruction.
- ex_mem_alu_result  in  32  ALU result; the memory address for loads/stores.
- ex_mem_store_data  in  32  rt value to store.
- ex_mem_rd  in  5  destination register.
- ex_mem_mem_ctrl  in  2  [1]=MemRead, [0]=MemWrite.
- ex_mem_wb_ctrl  in  2  [1]=RegWrite, [0]=MemToReg.
- stall  out  1  combinational; upstream holds EX/MEM and earlier stages.
- dmem_req  out  1  access request, registered.
- dmem_we  out  1  1=write, 0=read; valid while dmem_req=1.
- dmem_addr  out  32  word address; stable while dmem_req=1.
- dmem_wdata  out  32  store data; stable while dmem_req=1.
- dmem_ack  in  1  one-cycle completion pulse; dmem_rdata valid with it.
- dmem_rdata  in  32  load data.
- wb_valid  out  1  MEM/WB slot valid.
- wb_read_data  out  32  load data captured at ack.
- wb_alu_result  out  32  pass-through ALU result.
- wb_rd  out  5  pass-through destination register.
- wb_ctrl  out  2  pass-through WB control; RegWrite forced 0 on error.
- mem_err  out  1  one-cycle pulse in MEM/WB timing: misaligned, illegal control, or timeout.

Behaviour:
- Definitions:
  - mem_op = ex_mem_valid & (MemRead ^ MemWrite).
  - illegal = ex_mem_valid & MemRead & MemWrite.
  - misaligned = mem_op & (ex_mem_alu_result[1:0] != 0).
- FSM states: IDLE, ACCESS.
- IDLE:
  - mem_op & !misaligned: stall=1.
  - Next edge: state=ACCESS, dmem_req=1, dmem_we=MemWrite, dmem_addr/dmem_wdata latched from inputs, counter=0.
  - Otherwise: stall=0, state stays IDLE.
- ACCESS:
  - dmem_req, dmem_we, dmem_addr, dmem_wdata held constant.
  - stall = ~dmem_ack & (counter != TIMEOUT-1).
  - dmem_ack=1: next edge dmem_req=0, state=IDLE, wb_read_data=dmem_rdata for reads, 0 for writes.
  - Timeout (counter==TIMEOUT-1, no ack): next edge dmem_req=0, state=IDLE, wb_read_data=0, mem_err=1, wb_ctrl[1]=0.
  - Otherwise: counter increments.
- Latency: non-memory instructions take 1 cycle (same as a plain register). A memory op with ack on its first ACCESS cycle stalls exactly 1 extra cycle (2 cycles total).
- MEM/WB load on every edge:
  - stall=0: wb_* load from the current EX/MEM inputs (wb_read_data as above).
  - stall=1: wb_valid=0 (bubble); the other wb_* fields hold.
- Errors, resolved in IDLE with no stall and no dmem_req:
  - misaligned or illegal: wb_valid=1, wb_ctrl[1]=0, wb_read_data=0, mem_err=1.
  - Illegal control never issues a memory access.
- ex_mem_valid=0: wb_valid=0, mem_err=0, no access.
- dmem_ack in IDLE is ignored; no state change.
- The EX/MEM instruction is held by the stall. On the ack edge, stall=0, so EX/MEM advances at the same edge and the next IDLE cycle sees the new instruction. No double issue.
- Reset values: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, counter=0, wb_valid=0, wb_read_data=0, wb_alu_result=0, wb_rd=0, wb_ctrl=0, mem_err=0.
- stall=0 while rst=1.
- Reset mid-ACCESS: dmem_req drops at the reset edge and the access is abandoned. The data memory must tolerate an abandoned request; an ack arriving afterwards is ignored.

Decomposition:
- Shared package pipeline_pkg:
  - mem_state_t enum {IDLE, ACCESS}.
  - Bit indices MEMREAD_BIT=1, MEMWRITE_BIT=0, REGWRITE_BIT=1, MEMTOREG_BIT=0.
  - WORD_ALIGN_MASK=2'b11.
- One sub-module, mem_timeout_ctr:
  - Clear/enable counter with a terminal-count output.
  - Parameterised by TIMEOUT and CNT_W.

Test Plan:
1. ALU op (mem_ctrl=00, wb_ctrl=10, alu=0x0000_0042, rd=5) -> stall=0, no dmem_req; next cycle wb_valid=1, wb_alu_result=0x42, wb_rd=5, mem_err=0.
2. Load at 0x0000_0100, memory acks 3 cycles after req with rdata=0xDEAD_BEEF -> stall high 4 cycles, dmem_req held with addr 0x100 and we=0; edge after ack: wb_read_data=0xDEAD_BEEF, wb_valid=1, stall=0.
3. Store 0x1234_5678 to 0x0000_0200, ack on first ACCESS cycle -> dmem_we=1, dmem_wdata=0x1234_5678, exactly 1 stall cycle, wb_read_data=0, wb_valid=1.
4. Load at 0x0000_0102 (misaligned) -> no dmem_req, stall=0; next cycle mem_err=1, wb_ctrl[1]=0, wb_valid=1.
5. TIMEOUT=4, load, never ack -> stall=1 for 4 cycles, then dmem_req=0, mem_err=1, wb_ctrl[1]=0; a back-to-back second load then issues normally.
6. rst asserted on the 2nd ACCESS cycle of a load -> next edge all outputs at reset values, stall=0; a late dmem_ack causes no wb_valid and no state change.
